mano_io_ctrl: RTL and testbench

- Peripheral-side I/O controller feeding the datapath's INPR/FGI inputs and consuming OUTR/FGO.
- Buffers bytes from an external input device in a small FIFO and delivers each one into INPR with the FGI flag raised.
- Captures each byte the CPU writes to OUTR, presents it to an external output device with a valid/ready handshake, then re-raises FGO.
- Sits beside the datapath in the top level; flag flops stay in the datapath, and this block drives their load/data inputs.

---
 rtl/mano_io_ctrl_pkg.sv | 30 +++
 rtl/mano_io_ctrl_io_fifo.sv | 79 +++++++
 rtl/mano_io_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mano_io_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_io_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mano_io_ctrl_pkg
// Shared definitions for the Mano-style peripheral I/O controller:
//   - default I/O byte width and input FIFO depth
//   - state encodings for the input-delivery FSM and the output-handshake FSM
// No ports (package).
// -----------------------------------------------------------------------------
package mano_io_ctrl_pkg;

    localparam int IO_DATA_W     = 8;
    localparam int IO_FIFO_DEPTH = 4;

    // Input side: wait for a byte and FGI clear, pulse the INPR/FGI loads,
    // then wait for FGI to actually rise before considering the next byte.
    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_LOAD = 2'd1,
        IN_WAIT = 2'd2
    } in_state_t;

    // Output side: raise FGO once after reset, wait for the CPU to clear it
    // (OUT instruction), hand the byte to the device, then raise FGO again.
    typedef enum logic [1:0] {
        OUT_INIT  = 2'd0,
        OUT_FLAGW = 2'd1,
        OUT_READY = 2'd2,
        OUT_SEND  = 2'd3
    } out_state_t;

endpackage

// File: rtl/mano_io_ctrl_io_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Small synchronous FIFO buffering bytes from the input device.
// Ports:
//   mclk   in   clock, rising edge
//   mrst   in   asynchronous active-high reset (pointers and count only)
//   push   in   write din at the tail (ignored when full)
//   pop    in   drop the head entry (ignored when empty)
//   din    in   DATA_W byte to write
//   dout   out  DATA_W head entry, combinational read of the storage array
//   count  out  occupancy, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module io_fifo
    import mano_io_ctrl_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = IO_FIFO_DEPTH
) (
    input  logic                     mclk,
    input  logic                     mrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]     CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]     CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == CNT_FULL);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // NOTE: the storage array has no reset; only pointers and count are
    // cleared, so stale entries are unreachable and the array maps to plain RAM.
    always_ff @(posedge mclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register in
    // this block samples the pre-edge values regardless of statement order.
    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mano_io_ctrl.sv
// -----------------------------------------------------------------------------
// mano_io_ctrl
// Peripheral-side I/O controller beside the Mano datapath. Bytes from the
// input device are buffered and delivered into INPR with an FGI set pulse;
// bytes the CPU writes to OUTR are handed to the output device over a
// valid/ready handshake, after which FGO is set again.
// Ports:
//   mclk, mrst      clock / asynchronous active-high reset
//   dev_in_*        input device: data, valid in; ready out (FIFO not full)
//   dev_out_*       output device: data, valid out; ready in
//   fgi, fgo        current flag values from the datapath
//   outr            current OUTR contents from the datapath
//   inpr_data       byte for INPR
//   inpr_ld         one-cycle INPR load pulse
//   fgi_set         one-cycle FGI load pulse (datapath ties its data to 1)
//   fgo_set         one-cycle FGO load pulse (datapath ties its data to 1)
//   in_count        input FIFO occupancy
// -----------------------------------------------------------------------------
module mano_io_ctrl
    import mano_io_ctrl_pkg::*;
#(
    parameter int DATA_W     = IO_DATA_W,
    parameter int FIFO_DEPTH = IO_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              mclk,
    input  logic              mrst,
    input  logic [DATA_W-1:0] dev_in_data,
    input  logic              dev_in_valid,
    output logic              dev_in_ready,
    output logic [DATA_W-1:0] dev_out_data,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    input  logic              fgi,
    input  logic              fgo,
    input  logic [DATA_W-1:0] outr,
    output logic [DATA_W-1:0] inpr_data,
    output logic              inpr_ld,
    output logic              fgi_set,
    output logic              fgo_set,
    output logic [CNT_W-1:0]  in_count
);

    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // ---------------- input FIFO ----------------
    assign dev_in_ready = !w_full;
    assign w_push       = dev_in_valid && !w_full;

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .mclk  (mclk),
        .mrst  (mrst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (dev_in_data),
        .dout  (w_head),
        .count (in_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // ---------------- input FSM ----------------
    in_state_t         r_in_state;
    in_state_t         w_in_next;
    logic [DATA_W-1:0] r_inpr_data;
    logic              r_inpr_ld;
    logic              r_fgi_set;
    logic [DATA_W-1:0] w_inpr_data_nxt;
    logic              w_inpr_ld_nxt;
    logic              w_fgi_set_nxt;

    // The only pop point: a byte is waiting and the CPU has consumed the last one.
    assign w_pop = (r_in_state == IN_IDLE) && !w_empty && !fgi;

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            r_in_state  <= IN_IDLE;
            r_inpr_data <= '0;
            r_inpr_ld   <= 1'b0;
            r_fgi_set   <= 1'b0;
        end else begin
            r_in_state  <= w_in_next;
            r_inpr_data <= w_inpr_data_nxt;
            r_inpr_ld   <= w_inpr_ld_nxt;
            r_fgi_set   <= w_fgi_set_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_in_next = r_in_state;
        case (r_in_state)
            IN_IDLE: if (w_pop) w_in_next = IN_LOAD;
            IN_LOAD: w_in_next = IN_WAIT;
            // FGI only rises after the load cycle; waiting for it stops a
            // second delivery against a stale FGI=0.
            IN_WAIT: if (fgi) w_in_next = IN_IDLE;
            default: w_in_next = IN_IDLE;
        endcase
    end

    always_comb begin
        w_inpr_data_nxt = r_inpr_data;
        w_inpr_ld_nxt   = 1'b0;
        w_fgi_set_nxt   = 1'b0;
        if (w_pop) begin
            w_inpr_data_nxt = w_head;
            w_inpr_ld_nxt   = 1'b1;
            w_fgi_set_nxt   = 1'b1;
        end
    end

    assign inpr_data = r_inpr_data;
    assign inpr_ld   = r_inpr_ld;
    assign fgi_set   = r_fgi_set;

    // ---------------- output FSM ----------------
    out_state_t        r_out_state;
    out_state_t        w_out_next;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_fgo_set;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              w_out_valid_nxt;
    logic              w_fgo_set_nxt;
    logic              w_capture;
    logic              w_handshake;

    // fgo falling while ready means the CPU just loaded OUTR.
    assign w_capture   = (r_out_state == OUT_READY) && !fgo;
    assign w_handshake = (r_out_state == OUT_SEND) && dev_out_ready;

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            r_out_state <= OUT_INIT;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_fgo_set   <= 1'b0;
        end else begin
            r_out_state <= w_out_next;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_fgo_set   <= w_fgo_set_nxt;
        end
    end

    always_comb begin
        w_out_next = r_out_state;
        case (r_out_state)
            OUT_INIT:  w_out_next = OUT_FLAGW;
            OUT_FLAGW: if (fgo) w_out_next = OUT_READY;
            OUT_READY: if (w_capture) w_out_next = OUT_SEND;
            OUT_SEND:  if (w_handshake) w_out_next = OUT_FLAGW;
            default:   w_out_next = OUT_INIT;
        endcase
    end

    always_comb begin
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_fgo_set_nxt   = (r_out_state == OUT_INIT) || w_handshake;
        if (w_capture) begin
            w_out_data_nxt  = outr;
            w_out_valid_nxt = 1'b1;
        end else if (w_handshake) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    assign dev_out_data  = r_out_data;
    assign dev_out_valid = r_out_valid;
    assign fgo_set       = r_fgo_set;

endmodule

// File: tb/tb_mano_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mano_io_ctrl
// Self-checking bench for mano_io_ctrl. The bench plays the datapath (FGI/FGO
// flag flops loaded by the pulses), the CPU (clearing FGI after reading INPR,
// loading OUTR and clearing FGO) and both I/O devices. A queue of accepted
// bytes plus a few rule counters give the expected behaviour.
// -----------------------------------------------------------------------------
module tb_mano_io_ctrl;

    localparam int DEPTH = 4;

    logic       mclk = 1'b0;
    logic       mrst;
    logic [7:0] dev_in_data;
    logic       dev_in_valid;
    logic       dev_in_ready;
    logic [7:0] dev_out_data;
    logic       dev_out_valid;
    logic       dev_out_ready;
    logic       fgi;
    logic       fgo;
    logic [7:0] outr;
    logic [7:0] inpr_data;
    logic       inpr_ld;
    logic       fgi_set;
    logic       fgo_set;
    logic [2:0] in_count;

    always #5 mclk = ~mclk;

    mano_io_ctrl #(
        .DATA_W     (8),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (3)
    ) dut (
        .mclk          (mclk),
        .mrst          (mrst),
        .dev_in_data   (dev_in_data),
        .dev_in_valid  (dev_in_valid),
        .dev_in_ready  (dev_in_ready),
        .dev_out_data  (dev_out_data),
        .dev_out_valid (dev_out_valid),
        .dev_out_ready (dev_out_ready),
        .fgi           (fgi),
        .fgo           (fgo),
        .outr          (outr),
        .inpr_data     (inpr_data),
        .inpr_ld       (inpr_ld),
        .fgi_set       (fgi_set),
        .fgo_set       (fgo_set),
        .in_count      (in_count)
    );

    // ---------------- reference model state ----------------
    logic [7:0] in_q[$];       // bytes accepted, not yet delivered
    logic [7:0] deliv_log[$];  // bytes seen on inpr_data at each load pulse
    int         blk;           // 2: load cycle pending, 1: waiting FGI=1, 0: free
    bit         sending;       // output byte should be on the device port
    bit         pend;          // CPU has just written OUTR
    bit         init_pend;     // first edge after reset owes an FGO pulse
    bit         in_oneshot;    // drop dev_in_valid once a byte is taken
    logic [7:0] exp_out;
    int         fgo_age;       // edges FGO has been seen high
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        blk       = 0;
        sending   = 0;
        pend      = 0;
        init_pend = 1;
        fgo_age   = 0;
    endtask

    // One clock edge: predict from pre-edge values, then compare after the edge.
    task automatic step();
        logic       p_fgi, p_fgo, p_fgi_set, p_fgo_set, p_acc, p_hs, exp_ld, exp_fgo_set;
        logic [7:0] p_din, exp_byte;
        p_fgi       = fgi;
        p_fgo       = fgo;
        p_fgi_set   = fgi_set;
        p_fgo_set   = fgo_set;
        p_din       = dev_in_data;
        p_acc       = dev_in_valid && (in_q.size() != DEPTH);
        p_hs        = sending && dev_out_ready;
        exp_ld      = (blk == 0) && !p_fgi && (in_q.size() != 0);
        exp_fgo_set = init_pend || p_hs;
        exp_byte    = 8'h00;

        @(posedge mclk);
        #1;

        // datapath flag flops load on the pulses
        if (p_fgi_set) fgi = 1'b1;
        if (p_fgo_set) fgo = 1'b1;
        fgo_age = p_fgo ? fgo_age + 1 : 0;

        if (blk == 2)                blk = 1;
        else if (blk == 1 && p_fgi)  blk = 0;
        if (exp_ld) begin
            blk      = 2;
            exp_byte = in_q.pop_front();
        end
        if (p_acc) begin
            in_q.push_back(p_din);
            if (in_oneshot) dev_in_valid = 1'b0;
        end
        init_pend = 0;
        if (p_hs) sending = 0;
        if (pend) begin
            sending = 1;
            pend    = 0;
        end

        check("inpr_ld", inpr_ld, exp_ld);
        check("fgi_set", fgi_set, exp_ld);
        if (exp_ld) begin
            check("inpr_data", inpr_data, exp_byte);
            deliv_log.push_back(inpr_data);
        end
        check("in_count", in_count, in_q.size());
        check("dev_in_ready", dev_in_ready, in_q.size() != DEPTH);
        check("fgo_set", fgo_set, exp_fgo_set);
        check("dev_out_valid", dev_out_valid, sending);
        if (sending) check("dev_out_data", dev_out_data, exp_out);
    endtask

    // CPU reads INPR: clear FGI once the controller is free, wait for the load.
    task automatic deliver_one();
        for (int i = 0; i < 20 && blk != 0; i++) step();
        fgi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (inpr_ld) break;
        end
        if (!inpr_ld) check("deliver_timeout", inpr_ld, 1'b1);
    endtask

    // CPU OUT instruction: load OUTR and clear FGO together.
    task automatic cpu_out(input logic [7:0] b);
        for (int i = 0; i < 20 && !(fgo && fgo_age >= 1); i++) step();
        if (!(fgo && fgo_age >= 1)) check("fgo_wait_timeout", fgo, 1'b1);
        outr    = b;
        fgo     = 1'b0;
        pend    = 1;
        exp_out = b;
    endtask

    initial begin
        logic [7:0] b;
        mrst          = 1'b1;
        dev_in_data   = 8'h00;
        dev_in_valid  = 1'b0;
        dev_out_ready = 1'b0;
        fgi           = 1'b0;
        fgo           = 1'b0;
        outr          = 8'h00;
        in_oneshot    = 1;
        model_reset();

        // ---- reset state ----
        repeat (2) @(posedge mclk);
        #1;
        check("rst in_count", in_count, 0);
        check("rst inpr_data", inpr_data, 0);
        check("rst inpr_ld", inpr_ld, 0);
        check("rst fgi_set", fgi_set, 0);
        check("rst fgo_set", fgo_set, 0);
        check("rst dev_out_valid", dev_out_valid, 0);
        check("rst dev_out_data", dev_out_data, 0);
        check("rst dev_in_ready", dev_in_ready, 1);
        mrst = 1'b0;

        // ---- first edge raises FGO exactly once ----
        step();
        check("init fgo_set high", fgo_set, 1);
        step();
        check("init fgo_set one cycle", fgo_set, 0);
        step();
        check("ready idle valid", dev_out_valid, 0);
        check("ready idle count", in_count, 0);

        // ---- single byte latency ----
        dev_in_data  = 8'hA5;
        dev_in_valid = 1'b1;
        step();
        check("A5 no early ld", inpr_ld, 0);
        step();
        check("A5 ld", inpr_ld, 1);
        check("A5 data", inpr_data, 8'hA5);
        step();
        check("A5 ld one cycle", inpr_ld, 0);
        repeat (4) step();

        // ---- fill while FGI=1, then drain in order ----
        for (int i = 1; i <= 5; i++) begin
            dev_in_data  = 8'(i);
            dev_in_valid = 1'b1;
            step();
        end
        check("full count", in_count, DEPTH);
        check("full ready", dev_in_ready, 0);
        repeat (2) step();
        check("full stall", in_count, DEPTH);
        deliv_log.delete();
        repeat (5) deliver_one();
        check("order count", deliv_log.size(), 5);
        for (int i = 0; i < 5; i++) check("order byte", deliv_log[i], 32'(i + 1));

        // ---- pop on a full edge takes no push ----
        for (int i = 0; i < 20 && blk != 0; i++) step();
        for (int i = 0; i < DEPTH; i++) begin
            dev_in_data  = 8'($urandom());
            dev_in_valid = 1'b1;
            step();
        end
        check("refill count", in_count, DEPTH);
        dev_in_data  = 8'($urandom());
        dev_in_valid = 1'b1;
        fgi          = 1'b0;
        step();
        check("full pop count", in_count, DEPTH - 1);
        check("full pop ld", inpr_ld, 1);
        dev_in_valid = 1'b0;
        deliver_one();
        for (int i = 0; i < 20 && blk != 0; i++) step();
        check("pre pushpop count", in_count, 2);
        dev_in_data  = 8'($urandom());
        dev_in_valid = 1'b1;
        fgi          = 1'b0;
        step();
        check("pushpop count", in_count, 2);
        check("pushpop ld", inpr_ld, 1);
        repeat (2) deliver_one();
        step();
        check("drained count", in_count, 0);

        // ---- output handshake with back-pressure ----
        cpu_out(8'h3C);
        step();
        check("out valid", dev_out_valid, 1);
        check("out data", dev_out_data, 8'h3C);
        dev_out_ready = 1'b0;
        repeat (5) begin
            step();
            check("out hold valid", dev_out_valid, 1);
            check("out hold data", dev_out_data, 8'h3C);
        end
        dev_out_ready = 1'b1;
        step();
        check("out done valid", dev_out_valid, 0);
        check("out done fgo_set", fgo_set, 1);
        dev_out_ready = 1'b0;
        step();
        check("out fgo_set one cycle", fgo_set, 0);

        // ---- asynchronous reset mid-send with bytes queued ----
        cpu_out(8'($urandom()));
        step();
        check("send before rst", dev_out_valid, 1);
        for (int i = 0; i < 2; i++) begin
            dev_in_data  = 8'($urandom());
            dev_in_valid = 1'b1;
            step();
        end
        check("queued before rst", in_count, 2);
        #2;
        mrst = 1'b1;
        #1;
        check("async rst valid", dev_out_valid, 0);
        check("async rst count", in_count, 0);
        check("async rst inpr_ld", inpr_ld, 0);
        check("async rst fgo_set", fgo_set, 0);
        model_reset();
        fgi          = 1'b0;
        fgo          = 1'b0;
        dev_in_valid = 1'b0;
        @(posedge mclk);
        #1;
        mrst = 1'b0;
        step();
        check("reinit fgo_set", fgo_set, 1);

        // ---- randomized traffic on both sides ----
        in_oneshot = 0;
        repeat (800) begin
            dev_in_valid  = ($urandom_range(0, 2) != 0);
            dev_in_data   = 8'($urandom());
            dev_out_ready = ($urandom_range(0, 2) == 0);
            if (fgi && blk == 0 && $urandom_range(0, 3) == 0) fgi = 1'b0;
            if (fgo && fgo_age >= 1 && !pend && $urandom_range(0, 3) == 0) begin
                b       = 8'($urandom());
                outr    = b;
                fgo     = 1'b0;
                pend    = 1;
                exp_out = b;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
